perf_counter_bank: RTL

- Slave-side consumer of the perf_if control triggers; owns and drives the performance counter array.
- Per-counter event increments arrive from tile-local monitors.
- The bank edge-detects `clear_trigger` and `toggle_trigger`, gates counting with a run/stop state machine, and saturates each counter.
- It exposes `counter_r` plus sticky saturation flags to the master side for readout.

---
 rtl/perf_counter_bank.sv | 79 +++++++
 1 files changed

// File: rtl/perf_counter_bank.sv
// Bank of saturating performance counters gated by a run/stop state machine.
// Clear and run/stop requests are level inputs; only their rising edges take effect.
module perf_counter_bank #(
  parameter int unsigned perf_reg_num = 1,
  parameter int unsigned CNT_W        = 64,
  parameter int unsigned INC_W        = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    clear_trigger,
  input  logic                                    toggle_trigger,
  input  logic [perf_reg_num-1:0][INC_W-1:0]      event_inc,
  output logic [perf_reg_num-1:0][CNT_W-1:0]      counter_r,
  output logic [perf_reg_num-1:0]                 sat_flag,
  output logic                                    running
);

  localparam logic STOPPED = 1'b0;
  localparam logic RUNNING = 1'b1;

  logic state_q, state_d;
  logic clear_q, toggle_q;
  logic clr_pulse, tog_pulse;

  logic [perf_reg_num-1:0][CNT_W:0]   sum;
  logic [perf_reg_num-1:0][CNT_W-1:0] cnt_d;
  logic [perf_reg_num-1:0]            sat_d;

  assign clr_pulse = clear_trigger & ~clear_q;
  assign tog_pulse = toggle_trigger & ~toggle_q;

  always_comb begin
    state_d = state_q;
    if (tog_pulse) begin
      state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
    end
  end

  // Counting uses state_q, so a toggle edge only affects events from the next cycle.
  always_comb begin
    sum   = '0;
    cnt_d = counter_r;
    sat_d = sat_flag;
    for (int i = 0; i < int'(perf_reg_num); i++) begin
      sum[i] = {1'b0, counter_r[i]} + {{(CNT_W + 1 - INC_W){1'b0}}, event_inc[i]};
      if (clr_pulse) begin
        cnt_d[i] = '0;
        sat_d[i] = 1'b0;
      end else if (state_q == RUNNING) begin
        // Only a discarded carry flags saturation; landing on all-ones does not.
        if (sum[i][CNT_W]) begin
          cnt_d[i] = '1;
          sat_d[i] = 1'b1;
        end else begin
          cnt_d[i] = sum[i][CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STOPPED;
      clear_q   <= 1'b0;
      toggle_q  <= 1'b0;
      counter_r <= '0;
      sat_flag  <= '0;
    end else begin
      state_q   <= state_d;
      clear_q   <= clear_trigger;
      toggle_q  <= toggle_trigger;
      counter_r <= cnt_d;
      sat_flag  <= sat_d;
    end
  end

  assign running = (state_q == RUNNING);

endmodule
